bypass_rf_client: RTL and testbench

Issue-side client of the bypassing register file. Accepts decoded instructions (two source addresses, an optional destination) and performs the reservation handshakes atomically. It waits for both source operands to become valid, then hands them to execute. It forwards execute results into the RF's write port and frees write entries strictly in allocation order. It sits between decode and execute in every pipeline that uses the bypassing RF.

---
 rtl/bypass_rf_client_pkg.sv | 15 +
 rtl/bypass_rf_client_if.sv | 100 ++++++++++
 rtl/bypass_rf_client_rf_commit_tracker.sv | 80 ++++++++
 rtl/bypass_rf_client.sv | 130 +++++++++++++
 tb/tb_bypass_rf_client.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bypass_rf_client_pkg.sv
// Shared types and constants for the bypassing-RF issue client.
package bypass_rf_client_pkg;

    // Client FSM: IDLE holds nothing, WAIT holds a reserved instruction
    // whose operands may still be pending in the RF.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Read-slot names the client presents to the RF for its two sources.
    localparam int unsigned RD_SLOT_1 = 0;
    localparam int unsigned RD_SLOT_2 = 1;

endpackage

// File: rtl/bypass_rf_client_if.sv
// Bus bundle between the issue client and its neighbours: decode request,
// execute operand/result paths and the bypassing register file ports.
//
// Handshakes: a transfer happens on a cycle where both valid and ready are
// high; valid never waits on ready, and a source holding valid keeps its
// payload stable until the transfer cycle. REQ_READY is computed without
// looking at REQ_VALID, so decode may depend on it combinationally.
interface bypass_rf_client_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NAME_W = 2
);
    // decode -> client
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [ADDR_W-1:0] REQ_RS1;
    logic [ADDR_W-1:0] REQ_RS2;
    logic [ADDR_W-1:0] REQ_RD;
    logic              REQ_WR;
    // client -> execute
    logic              OP_VALID;
    logic              OP_READY;
    logic [DATA_W-1:0] OP_A;
    logic [DATA_W-1:0] OP_B;
    logic [NAME_W-1:0] OP_NAME;
    logic              OP_WR;
    // execute -> client
    logic              RES_VALID;
    logic [NAME_W-1:0] RES_NAME;
    logic [DATA_W-1:0] RES_DATA;
    // client <-> register file
    logic [ADDR_W-1:0] RF_ADDR_IN;
    logic              RF_ALLOC_E;
    logic              RF_ALLOC_READY;
    logic [NAME_W-1:0] RF_NAME_OUT;
    logic [ADDR_W-1:0] RF_ADDR_1;
    logic [ADDR_W-1:0] RF_ADDR_2;
    logic              RF_RRESE_1;
    logic              RF_RRESE_2;
    logic              RF_RRES_READY_1;
    logic              RF_RRES_READY_2;
    logic [NAME_W-1:0] RF_NAME_IN_1;
    logic [DATA_W-1:0] RF_D_IN_1;
    logic              RF_WE_1;
    logic [NAME_W-1:0] RF_NAME_IN_2;
    logic [DATA_W-1:0] RF_D_IN_2;
    logic              RF_WE_2;
    logic [NAME_W-1:0] RF_RD_NAME_1;
    logic [NAME_W-1:0] RF_RD_NAME_2;
    logic [DATA_W-1:0] RF_D_OUT_1;
    logic [DATA_W-1:0] RF_D_OUT_2;
    logic              RF_VALID_OUT_1;
    logic              RF_VALID_OUT_2;
    logic [NAME_W-1:0] RF_W_F;
    logic              RF_WFE;
    logic              RF_F_READY;
    logic              RF_FE_1;
    logic              RF_FE_2;

    // The client itself.
    modport slave (
        input  REQ_VALID, REQ_RS1, REQ_RS2, REQ_RD, REQ_WR,
        output REQ_READY,
        output OP_VALID, OP_A, OP_B, OP_NAME, OP_WR,
        input  OP_READY,
        input  RES_VALID, RES_NAME, RES_DATA,
        output RF_ADDR_IN, RF_ALLOC_E,
        input  RF_ALLOC_READY, RF_NAME_OUT,
        output RF_ADDR_1, RF_ADDR_2, RF_RRESE_1, RF_RRESE_2,
        input  RF_RRES_READY_1, RF_RRES_READY_2,
        output RF_NAME_IN_1, RF_D_IN_1, RF_WE_1,
        output RF_NAME_IN_2, RF_D_IN_2, RF_WE_2,
        output RF_RD_NAME_1, RF_RD_NAME_2,
        input  RF_D_OUT_1, RF_D_OUT_2, RF_VALID_OUT_1, RF_VALID_OUT_2,
        output RF_W_F, RF_WFE,
        input  RF_F_READY,
        output RF_FE_1, RF_FE_2
    );

    // Everything around the client: decode, execute and the RF.
    modport master (
        output REQ_VALID, REQ_RS1, REQ_RS2, REQ_RD, REQ_WR,
        input  REQ_READY,
        input  OP_VALID, OP_A, OP_B, OP_NAME, OP_WR,
        output OP_READY,
        output RES_VALID, RES_NAME, RES_DATA,
        input  RF_ADDR_IN, RF_ALLOC_E,
        output RF_ALLOC_READY, RF_NAME_OUT,
        input  RF_ADDR_1, RF_ADDR_2, RF_RRESE_1, RF_RRESE_2,
        output RF_RRES_READY_1, RF_RRES_READY_2,
        input  RF_NAME_IN_1, RF_D_IN_1, RF_WE_1,
        input  RF_NAME_IN_2, RF_D_IN_2, RF_WE_2,
        input  RF_RD_NAME_1, RF_RD_NAME_2,
        output RF_D_OUT_1, RF_D_OUT_2, RF_VALID_OUT_1, RF_VALID_OUT_2,
        input  RF_W_F, RF_WFE,
        output RF_F_READY,
        input  RF_FE_1, RF_FE_2
    );

endinterface

// File: rtl/bypass_rf_client_rf_commit_tracker.sv
// Tracks outstanding RF write names: which are allocated (pend), which have
// their result written (wr), and retires them strictly in allocation order.
module rf_commit_tracker #(
    parameter int NAME_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              alloc_e,
    input  logic [NAME_W-1:0] alloc_name,
    input  logic              res_valid,
    input  logic [NAME_W-1:0] res_name,
    input  logic              f_ready,
    output logic              we,
    output logic [NAME_W-1:0] w_f,
    output logic              wfe,
    output logic              full,
    output logic [NAME_W:0]   count
);

    localparam int DEPTH = 1 << NAME_W;
    localparam logic [NAME_W-1:0] NAME_ONE = 1;
    localparam logic [NAME_W:0]   CNT_ONE  = 1;

    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DEPTH-1:0]  wr_q, wr_d;
    logic [NAME_W-1:0] cptr_q, cptr_d;
    logic [NAME_W:0]   count_q, count_d;

    // Result gating and commit request; both held low during reset.
    always_comb begin
        we   = !RST && res_valid && pend_q[res_name] && !wr_q[res_name];
        wfe  = !RST && pend_q[cptr_q] && wr_q[cptr_q] && f_ready;
        w_f  = cptr_q;
        // count never exceeds DEPTH, so its top bit alone means "full".
        full  = count_q[NAME_W];
        count = count_q;
    end

    // Next tracker state. The commit slot is cleared before the alloc slot
    // is set; they can only coincide when nothing is pending, in which case
    // no commit is possible anyway.
    always_comb begin
        pend_d  = pend_q;
        wr_d    = wr_q;
        cptr_d  = cptr_q;
        count_d = count_q;
        if (wfe) begin
            pend_d[cptr_q] = 1'b0;
            wr_d[cptr_q]   = 1'b0;
            cptr_d         = cptr_q + NAME_ONE;
        end
        if (alloc_e) begin
            pend_d[alloc_name] = 1'b1;
        end
        if (we) begin
            wr_d[res_name] = 1'b1;
        end
        case ({alloc_e, wfe})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Tracker registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q  <= '0;
            wr_q    <= '0;
            cptr_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            cptr_q  <= cptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bypass_rf_client.sv
// Issue-side client of the bypassing register file: reserves both source
// reads and the destination write atomically, waits for operands, hands
// them to execute, and routes execute results back into the RF.
module bypass_rf_client
    import bypass_rf_client_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NAME_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    bypass_rf_client_if.slave bus,
    output state_e            dbg_state,
    output logic [NAME_W:0]   dbg_count
);

    state_e            state_q, state_d;
    logic [NAME_W-1:0] op_name_q, op_name_d;
    logic              op_wr_q, op_wr_d;

    logic op_valid;
    logic opfire;
    logic canres;
    logic req_ready;
    logic accept;
    logic alloc_e;
    logic full;
    logic res_we;
    logic wfe;
    logic [NAME_W-1:0] w_f;
    logic [NAME_W:0]   trk_count;

    // State and latched instruction fields.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            op_name_q <= '0;
            op_wr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_name_q <= op_name_d;
            op_wr_q   <= op_wr_d;
        end
    end

    // Next state: a new accept always wins (it also covers the same-cycle
    // free + reserve case); a bare operand transfer returns to IDLE.
    always_comb begin
        state_d   = state_q;
        op_name_d = op_name_q;
        op_wr_d   = op_wr_q;
        if (accept) begin
            state_d   = WAIT;
            op_name_d = bus.RF_NAME_OUT;
            op_wr_d   = bus.REQ_WR;
        end else if (opfire) begin
            state_d = IDLE;
        end
    end

    // Handshake decode. All three reservations key off the single accept
    // term so they fire together or not at all.
    always_comb begin
        op_valid  = !RST && (state_q == WAIT) &&
                    bus.RF_VALID_OUT_1 && bus.RF_VALID_OUT_2;
        opfire    = op_valid && bus.OP_READY;
        canres    = bus.RF_RRES_READY_1 && bus.RF_RRES_READY_2 &&
                    (!bus.REQ_WR || (bus.RF_ALLOC_READY && !full));
        req_ready = !RST && ((state_q == IDLE) || opfire) && canres;
        accept    = bus.REQ_VALID && req_ready;
        alloc_e   = accept && bus.REQ_WR;
    end

    rf_commit_tracker #(
        .NAME_W (NAME_W)
    ) u_tracker (
        .CLK        (CLK),
        .RST        (RST),
        .alloc_e    (alloc_e),
        .alloc_name (bus.RF_NAME_OUT),
        .res_valid  (bus.RES_VALID),
        .res_name   (bus.RES_NAME),
        .f_ready    (bus.RF_F_READY),
        .we         (res_we),
        .w_f        (w_f),
        .wfe        (wfe),
        .full       (full),
        .count      (trk_count)
    );

    // Decode side
    assign bus.REQ_READY    = req_ready;

    // Execute side: operands pass straight through from the RF read ports
    assign bus.OP_VALID     = op_valid;
    assign bus.OP_A         = bus.RF_D_OUT_1;
    assign bus.OP_B         = bus.RF_D_OUT_2;
    assign bus.OP_NAME      = op_name_q;
    assign bus.OP_WR        = op_wr_q;

    // RF reservation ports
    assign bus.RF_ADDR_1    = bus.REQ_RS1;
    assign bus.RF_ADDR_2    = bus.REQ_RS2;
    assign bus.RF_ADDR_IN   = ADDR_W'(bus.REQ_RD);
    assign bus.RF_RRESE_1   = accept;
    assign bus.RF_RRESE_2   = accept;
    assign bus.RF_ALLOC_E   = alloc_e;
    assign bus.RF_RD_NAME_1 = NAME_W'(RD_SLOT_1);
    assign bus.RF_RD_NAME_2 = NAME_W'(RD_SLOT_2);

    // RF write ports: port 1 carries execute results, port 2 is unused
    assign bus.RF_NAME_IN_1 = bus.RES_NAME;
    assign bus.RF_D_IN_1    = bus.RES_DATA;
    assign bus.RF_WE_1      = res_we;
    assign bus.RF_NAME_IN_2 = '0;
    assign bus.RF_D_IN_2    = {DATA_W{1'b0}};
    assign bus.RF_WE_2      = 1'b0;

    // RF commit and read-slot frees
    assign bus.RF_W_F       = w_f;
    assign bus.RF_WFE       = wfe;
    assign bus.RF_FE_1      = opfire;
    assign bus.RF_FE_2      = opfire;

    // Debug visibility
    assign dbg_state        = state_q;
    assign dbg_count        = trk_count;

endmodule

// File: tb/tb_bypass_rf_client.sv
// Directed table-driven bench for bypass_rf_client with NAME_W=2.
module tb_bypass_rf_client;
    import bypass_rf_client_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    state_e     dbg_state;
    logic [2:0] dbg_count;

    int n_vec = 0;
    int n_err = 0;

    bypass_rf_client_if #(.ADDR_W(5), .DATA_W(32), .NAME_W(2)) bus ();

    bypass_rf_client #(.ADDR_W(5), .DATA_W(32), .NAME_W(2)) dut (
        .CLK       (clk),
        .RST       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected in that cycle.
    // rr/vv: bit0 = slot 1, bit1 = slot 2.
    typedef struct {
        logic       rst, rv, rwr;
        logic [4:0] rs1, rs2, rd;
        logic [1:0] nm;
        logic       ar;
        logic [1:0] rr, vv;
        logic       ordy, resv;
        logic [1:0] resn;
        logic       fr;
        logic       e_rr, e_rres, e_al, e_ov;
        logic [1:0] e_on;
        logic       e_ow, e_fe, e_we, e_wfe;
        logic [1:0] e_wf;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int rst_i, int rv, int rwr, int rs1, int rs2, int rd,
                                int nm, int ar, int rr, int vv, int ordy, int resv,
                                int resn, int fr, int e_rr, int e_rres, int e_al,
                                int e_ov, int e_on, int e_ow, int e_fe, int e_we,
                                int e_wfe, int e_wf, int e_cnt);
        vec_t v;
        v.rst = 1'(rst_i); v.rv = 1'(rv); v.rwr = 1'(rwr);
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.nm = 2'(nm); v.ar = 1'(ar); v.rr = 2'(rr); v.vv = 2'(vv);
        v.ordy = 1'(ordy); v.resv = 1'(resv); v.resn = 2'(resn); v.fr = 1'(fr);
        v.e_rr = 1'(e_rr); v.e_rres = 1'(e_rres); v.e_al = 1'(e_al);
        v.e_ov = 1'(e_ov); v.e_on = 2'(e_on); v.e_ow = 1'(e_ow);
        v.e_fe = 1'(e_fe); v.e_we = 1'(e_we); v.e_wfe = 1'(e_wfe);
        v.e_wf = 2'(e_wf); v.e_cnt = 3'(e_cnt);
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Drive one vector after the rising edge, check on the falling edge.
    task automatic apply(input vec_t v, input int idx);
        logic [31:0] da, db, dr;
        da = 32'hA000_0000 + 32'(idx);
        db = 32'hB000_0000 + 32'(idx);
        dr = 32'hD000_0000 + 32'(idx);
        rst                 = v.rst;
        bus.REQ_VALID       = v.rv;
        bus.REQ_WR          = v.rwr;
        bus.REQ_RS1         = v.rs1;
        bus.REQ_RS2         = v.rs2;
        bus.REQ_RD          = v.rd;
        bus.RF_NAME_OUT     = v.nm;
        bus.RF_ALLOC_READY  = v.ar;
        bus.RF_RRES_READY_1 = v.rr[0];
        bus.RF_RRES_READY_2 = v.rr[1];
        bus.RF_VALID_OUT_1  = v.vv[0];
        bus.RF_VALID_OUT_2  = v.vv[1];
        bus.RF_D_OUT_1      = da;
        bus.RF_D_OUT_2      = db;
        bus.OP_READY        = v.ordy;
        bus.RES_VALID       = v.resv;
        bus.RES_NAME        = v.resn;
        bus.RES_DATA        = dr;
        bus.RF_F_READY      = v.fr;
        @(negedge clk);
        n_vec++;
        chk(idx, "req_ready", 32'(bus.REQ_READY),  32'(v.e_rr));
        chk(idx, "rrese_1",   32'(bus.RF_RRESE_1), 32'(v.e_rres));
        chk(idx, "rrese_2",   32'(bus.RF_RRESE_2), 32'(v.e_rres));
        chk(idx, "alloc_e",   32'(bus.RF_ALLOC_E), 32'(v.e_al));
        chk(idx, "op_valid",  32'(bus.OP_VALID),   32'(v.e_ov));
        chk(idx, "op_name",   32'(bus.OP_NAME),    32'(v.e_on));
        chk(idx, "op_wr",     32'(bus.OP_WR),      32'(v.e_ow));
        chk(idx, "op_a",      bus.OP_A,            da);
        chk(idx, "op_b",      bus.OP_B,            db);
        chk(idx, "fe_1",      32'(bus.RF_FE_1),    32'(v.e_fe));
        chk(idx, "fe_2",      32'(bus.RF_FE_2),    32'(v.e_fe));
        chk(idx, "we_1",      32'(bus.RF_WE_1),    32'(v.e_we));
        chk(idx, "wfe",       32'(bus.RF_WFE),     32'(v.e_wfe));
        chk(idx, "w_f",       32'(bus.RF_W_F),     32'(v.e_wf));
        chk(idx, "count",     32'(dbg_count),      32'(v.e_cnt));
        chk(idx, "addr_1",    32'(bus.RF_ADDR_1),  32'(v.rs1));
        chk(idx, "addr_2",    32'(bus.RF_ADDR_2),  32'(v.rs2));
        chk(idx, "addr_in",   32'(bus.RF_ADDR_IN), 32'(v.rd));
        chk(idx, "name_in_1", 32'(bus.RF_NAME_IN_1), 32'(v.resn));
        chk(idx, "d_in_1",    bus.RF_D_IN_1,       dr);
        chk(idx, "tie_port2", {bus.RF_D_IN_2[29:0], bus.RF_NAME_IN_2}, 32'd0);
        chk(idx, "tie_we_2",  32'(bus.RF_WE_2),    32'd0);
        chk(idx, "rd_name_1", 32'(bus.RF_RD_NAME_1), 32'd0);
        chk(idx, "rd_name_2", 32'(bus.RF_RD_NAME_2), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.REQ_VALID = 1'b0; bus.REQ_WR = 1'b0;
        bus.REQ_RS1 = '0; bus.REQ_RS2 = '0; bus.REQ_RD = '0;
        bus.RF_NAME_OUT = '0; bus.RF_ALLOC_READY = 1'b0;
        bus.RF_RRES_READY_1 = 1'b0; bus.RF_RRES_READY_2 = 1'b0;
        bus.RF_VALID_OUT_1 = 1'b0; bus.RF_VALID_OUT_2 = 1'b0;
        bus.RF_D_OUT_1 = '0; bus.RF_D_OUT_2 = '0;
        bus.OP_READY = 1'b0; bus.RES_VALID = 1'b0; bus.RES_NAME = '0;
        bus.RES_DATA = '0; bus.RF_F_READY = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //        rst rv wr rs1 rs2 rd nm ar rr vv ordy resv resn fr | rr rres al ov on ow fe we wfe wf cnt
        // reset held with every input active: all enables low
        vt.push_back(mk(1, 1, 1, 3, 4, 5, 0, 1, 3, 3, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // first writing instruction, all reservations together
        vt.push_back(mk(0, 1, 1, 3, 4, 5, 0, 1, 3, 0, 1, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // operands valid next cycle, name 0, handed off
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 1, 0, 0, 1,  1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1));
        // slot-2 read reservation not ready: nothing fires
        vt.push_back(mk(0, 1, 1, 1, 2, 6, 1, 1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 1, 2, 6, 1, 1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        // ready returns
        vt.push_back(mk(0, 1, 1, 1, 2, 6, 1, 1, 3, 0, 1, 0, 0, 1,  1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1));
        // back-to-back free + reserve, names 2 and 3
        vt.push_back(mk(0, 1, 1, 2, 3, 7, 2, 1, 3, 3, 1, 0, 0, 1,  1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 2));
        vt.push_back(mk(0, 1, 1, 3, 4, 8, 3, 1, 3, 3, 1, 0, 0, 1,  1, 1, 1, 1, 2, 1, 1, 0, 0, 0, 3));
        // four names outstanding: fifth writing request stalls
        vt.push_back(mk(0, 1, 1, 4, 5, 9, 0, 1, 3, 3, 1, 0, 0, 1,  0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 4));
        vt.push_back(mk(0, 1, 1, 4, 5, 9, 0, 1, 3, 0, 1, 0, 0, 1,  0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 4));
        // non-writing request still accepted, alloc-ready irrelevant
        vt.push_back(mk(0, 1, 0, 7, 8, 9, 2, 0, 3, 0, 1, 0, 0, 1,  1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 4));
        // results for name 1 then name 0
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 1, 1,  0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 4));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 0, 1,  0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 4));
        // commit name 0, then name 1 next cycle
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 1,  0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 4));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 1,  0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 3));
        // result for name 2, then a duplicate (suppressed) with commit held off
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 2, 1,  0, 0, 0, 0, 2, 0, 0, 1, 0, 2, 2));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 2, 0,  0, 0, 0, 0, 2, 0, 0, 0, 0, 2, 2));
        // result for an already-retired name is dropped
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 1, 0,  0, 0, 0, 0, 2, 0, 0, 0, 0, 2, 2));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 1,  0, 0, 0, 0, 2, 0, 0, 0, 1, 2, 2));

        foreach (vt[i]) apply(vt[i], i);

        // Execute stalls for 3 cycles: outputs hold, no read-slot free.
        for (int k = 0; k < 3; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 1,  0, 0, 0, 1, 2, 0, 0, 0, 0, 3, 1), 100);
        // Release with a same-cycle writing accept (name 0 is free again).
        apply(mk(0, 1, 1, 10, 11, 12, 0, 1, 3, 3, 1, 0, 0, 1,  1, 1, 1, 1, 2, 0, 1, 0, 0, 3, 1), 100);
        // New instruction waits at execute; result for name 3 arrives.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 1, 3, 1,  0, 0, 0, 1, 0, 1, 0, 1, 0, 3, 2), 101);

        // Reset mid-WAIT: enables gated low even with a pending result and a
        // committable name; next cycle the client is empty.
        apply(mk(1, 1, 1, 1, 1, 1, 1, 1, 3, 3, 1, 1, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 2), 102);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 103);
        chk(103, "state_after_rst", 32'(dbg_state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
